// File: rtl/awg_pkg.sv
// awg_pkg: shared waveform codes, default widths and sequencer state for the AWG blocks
package awg_pkg;
    localparam int FREQ_W = 17;
    localparam int AMP_W  = 10;
    localparam logic [1:0] WAVE_SINE   = 2'b00;
    localparam logic [1:0] WAVE_TRI    = 2'b01;
    localparam logic [1:0] WAVE_SAW    = 2'b10;
    localparam logic [1:0] WAVE_SQUARE = 2'b11;
    typedef enum logic {IDLE, RUN} state_e;
endpackage

// File: rtl/awg_dwell_timer.sv
// awg_dwell_timer: auto-reloading down-counter; tc_o marks the last clock of each period
// Ports: clk, rst_n (async active-low), load_i (capture period_i and restart),
//        en_i (count enable), period_i (clocks per period minus one), tc_o (terminal count)
module awg_dwell_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] period_i,
    output logic         tc_o
);
    logic [W-1:0] period_q, count_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= '0;
            count_q  <= '0;
        end else if (load_i) begin
            period_q <= period_i;
            count_q  <= period_i;
        end else if (en_i) begin
            count_q <= (count_q == '0) ? period_q : count_q - 1'b1;
        end
    end
    assign tc_o = en_i && (count_q == '0);
endmodule

// File: rtl/awg_sweep_controller.sv
// awg_sweep_controller: runs frequency sweeps by driving the waveform generator configuration
// Ports: clk, rst_n (async active-low); start/abort pulses; cfg_* sweep profile latched on start;
//        waveform_type/frequency/amplitude/dc_offset to generator (0 when idle);
//        busy (in RUN), sweep_wrap, done, aborted (1-cycle status pulses). All outputs registered.
module awg_sweep_controller
    import awg_pkg::*;
#(
    parameter int FREQ_W  = awg_pkg::FREQ_W,
    parameter int AMP_W   = awg_pkg::AMP_W,
    parameter int DWELL_W = 24,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [1:0]         cfg_wave_type,
    input  logic [FREQ_W-1:0]  cfg_start_freq,
    input  logic [FREQ_W-1:0]  cfg_stop_freq,
    input  logic [FREQ_W-1:0]  cfg_step_freq,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [CNT_W-1:0]   cfg_num_sweeps,
    input  logic [AMP_W-1:0]   cfg_amplitude,
    input  logic [AMP_W-1:0]   cfg_dc_offset,
    output logic [1:0]         waveform_type,
    output logic [FREQ_W-1:0]  frequency,
    output logic [AMP_W-1:0]   amplitude,
    output logic [AMP_W-1:0]   dc_offset,
    output logic               busy,
    output logic               sweep_wrap,
    output logic               done,
    output logic               aborted
);
    state_e              state_q;
    logic [FREQ_W-1:0]   start_q, stop_q, step_q, freq_q, freq_d;
    logic [CNT_W-1:0]    num_q, cnt_q, cnt_d;
    logic [AMP_W-1:0]    amp_q, off_q, amp_room;
    logic [1:0]          wave_q;
    logic                up_q, wrap_q, done_q, aborted_q;
    logic                launch, tc, last_pt;
    logic [FREQ_W:0]     sum, diff;
    logic [DWELL_W-1:0]  period;

    assign launch   = (state_q == IDLE) && start && !abort;
    // Timer holds D-1 so a dwell of 0 behaves as 1 clock per point.
    assign period   = (cfg_dwell == '0) ? '0 : cfg_dwell - 1'b1;
    assign amp_room = {AMP_W{1'b1}} - cfg_dc_offset;
    // One extra bit catches wrap-around so it clamps to stop like an overshoot.
    assign sum      = {1'b0, freq_q} + {1'b0, step_q};
    assign diff     = {1'b0, freq_q} - {1'b0, step_q};
    assign last_pt  = (freq_q == stop_q) || (step_q == '0);
    assign cnt_d    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        freq_d = up_q ? ((sum[FREQ_W] || sum[FREQ_W-1:0] > stop_q) ? stop_q : sum[FREQ_W-1:0])
                      : ((diff[FREQ_W] || diff[FREQ_W-1:0] < stop_q) ? stop_q : diff[FREQ_W-1:0]);
    end

    awg_dwell_timer #(.W(DWELL_W)) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (launch),
        .en_i     (state_q == RUN),
        .period_i (period),
        .tc_o     (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            start_q   <= '0;
            stop_q    <= '0;
            step_q    <= '0;
            freq_q    <= '0;
            num_q     <= '0;
            cnt_q     <= '0;
            amp_q     <= '0;
            off_q     <= '0;
            wave_q    <= '0;
            up_q      <= 1'b0;
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            wrap_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            if (state_q == IDLE) begin
                if (launch) begin
                    state_q <= RUN;
                    start_q <= cfg_start_freq;
                    stop_q  <= cfg_stop_freq;
                    step_q  <= cfg_step_freq;
                    num_q   <= cfg_num_sweeps;
                    up_q    <= cfg_stop_freq >= cfg_start_freq;
                    cnt_q   <= '0;
                    freq_q  <= cfg_start_freq;
                    wave_q  <= cfg_wave_type;
                    amp_q   <= (cfg_amplitude > amp_room) ? amp_room : cfg_amplitude;
                    off_q   <= cfg_dc_offset;
                end
            end else if (abort) begin
                state_q   <= IDLE;
                freq_q    <= '0;
                amp_q     <= '0;
                off_q     <= '0;
                wave_q    <= '0;
                aborted_q <= 1'b1;
            end else if (tc) begin
                if (!last_pt) begin
                    freq_q <= freq_d;
                end else begin
                    cnt_q <= cnt_d;
                    if (num_q != '0 && cnt_d == num_q) begin
                        state_q <= IDLE;
                        freq_q  <= '0;
                        amp_q   <= '0;
                        off_q   <= '0;
                        wave_q  <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        freq_q <= start_q;
                        wrap_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign busy          = (state_q == RUN);
    assign frequency     = freq_q;
    assign amplitude     = amp_q;
    assign dc_offset     = off_q;
    assign waveform_type = wave_q;
    assign sweep_wrap    = wrap_q;
    assign done          = done_q;
    assign aborted       = aborted_q;
endmodule
